// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: default widths, legal oversampling ratios
// and bit_cnt indices used by the sampler and the RX control FSM.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W_DEF = 6;
    localparam int unsigned BIT_CNT_W_DEF  = 4;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    localparam int unsigned START_IDX      = 0;
    localparam int unsigned FIRST_DATA_IDX = 1;
    localparam int unsigned LAST_DATA_IDX  = 8;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/rx_sync_ff.sv
// Multi-flop synchroniser for the serial line; every stage presets to idle (1).
module rx_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rx_edge_bit_sampler.sv
// UART RX timing front end: line synchroniser, oversample/bit counters and
// a three-sample mid-bit majority voter.
module rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF,
    parameter int unsigned BIT_CNT_W   = BIT_CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  data_sample_enable,
    input  logic                  reset_counters,
    output logic                  rx_sync,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  prescale_err
);

    logic                  s0, s1, s2;
    logic [PRESCALE_W:0]   edge_inc;
    logic                  at_wrap;
    logic [PRESCALE_W-1:0] mid;
    logic                  vote;

    rx_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK(CLK),
        .RST(RST),
        .d  (RX_IN),
        .q  (rx_sync)
    );

    // Wrap on edge_cnt >= prescale-1, so a prescale lowered mid-bit still wraps.
    always_comb begin
        edge_inc = {1'b0, edge_cnt} + (PRESCALE_W+1)'(1);
        at_wrap  = edge_inc >= {1'b0, prescale};
        mid      = prescale >> 1;
        vote     = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_err <= 1'b0;
        end else begin
            prescale_err <= !prescale_legal(32'(prescale));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (reset_counters) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable && at_wrap) begin
            edge_cnt <= '0;
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end else if (enable) begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            s2           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (enable && data_sample_enable) begin
                if (edge_cnt == mid - PRESCALE_W'(1)) s0 <= rx_sync;
                if (edge_cnt == mid)                  s1 <= rx_sync;
                if (edge_cnt == mid + PRESCALE_W'(1)) s2 <= rx_sync;
                // Vote one cycle after the last capture so s2 is already settled.
                if (edge_cnt == mid + PRESCALE_W'(2) && !prescale_err) begin
                    sampled_bit  <= vote;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Self-checking bench for rx_edge_bit_sampler: counters are predicted from the
// count of enabled cycles, recovered bits from a majority of the planned line.
module tb_rx_edge_bit_sampler;

    localparam int P_W = 6;
    localparam int B_W = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           RX_IN;
    logic [P_W-1:0] prescale;
    logic           enable;
    logic           data_sample_enable;
    logic           reset_counters;
    logic           rx_sync;
    logic [P_W-1:0] edge_cnt;
    logic [B_W-1:0] bit_cnt;
    logic           sampled_bit;
    logic           sample_valid;
    logic           prescale_err;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_sb;
    logic line [0:511];

    always #5 CLK = ~CLK;

    rx_edge_bit_sampler #(
        .SYNC_STAGES(2),
        .PRESCALE_W (P_W),
        .BIT_CNT_W  (B_W)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .RX_IN             (RX_IN),
        .prescale          (prescale),
        .enable            (enable),
        .data_sample_enable(data_sample_enable),
        .reset_counters    (reset_counters),
        .rx_sync           (rx_sync),
        .edge_cnt          (edge_cnt),
        .bit_cnt           (bit_cnt),
        .sampled_bit       (sampled_bit),
        .sample_valid      (sample_valid),
        .prescale_err      (prescale_err)
    );

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_counters;
        enable = 1'b0;
        data_sample_enable = 1'b0;
        reset_counters = 1'b1;
        step;
        reset_counters = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0; RX_IN = 1'b1; prescale = P_W'(8);
        enable = 1'b0; data_sample_enable = 1'b0; reset_counters = 1'b0;
        #12;
        n_vec += 6;
        if (rx_sync !== 1'b1)      begin n_err++; $display("FAIL reset_rx_sync got %b exp 1", rx_sync); end
        if (edge_cnt !== '0)       begin n_err++; $display("FAIL reset_edge got %0d exp 0", edge_cnt); end
        if (bit_cnt !== '0)        begin n_err++; $display("FAIL reset_bit got %0d exp 0", bit_cnt); end
        if (sampled_bit !== 1'b1)  begin n_err++; $display("FAIL reset_sampled got %b exp 1", sampled_bit); end
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        if (prescale_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b exp 0", prescale_err); end
        step;
        RST = 1'b1;
        step;
        clear_counters;
        enable = 1'b1;
        repeat (29) step;
        n_vec += 2;
        if (edge_cnt !== P_W'(5)) begin n_err++; $display("FAIL midcount_edge got %0d exp 5", edge_cnt); end
        if (bit_cnt !== B_W'(3))  begin n_err++; $display("FAIL midcount_bit got %0d exp 3", bit_cnt); end
        #2;
        RX_IN = 1'b0;
        RST = 1'b0;
        #1;
        n_vec += 5;
        if (rx_sync !== 1'b1)      begin n_err++; $display("FAIL async_rx_sync got %b exp 1", rx_sync); end
        if (edge_cnt !== '0)       begin n_err++; $display("FAIL async_edge got %0d exp 0", edge_cnt); end
        if (bit_cnt !== '0)        begin n_err++; $display("FAIL async_bit got %0d exp 0", bit_cnt); end
        if (sampled_bit !== 1'b1)  begin n_err++; $display("FAIL async_sampled got %b exp 1", sampled_bit); end
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got %b exp 0", sample_valid); end
        step;
        RST = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic exp_rs = (i < 2) ? 1'b1 : 1'b0;
            n_vec++;
            if (rx_sync !== exp_rs) begin
                n_err++; $display("FAIL sync_latency cyc=%0d got %b exp %b", i, rx_sync, exp_rs);
            end
            step;
        end
        RX_IN = 1'b1;
        step; step;
        exp_sb = 1'b1;
    endtask

    task automatic test_wrap;
        prescale = P_W'(8);
        clear_counters;
        enable = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            logic [P_W-1:0] ee = P_W'(i % 8);
            logic [B_W-1:0] eb = B_W'(i / 8);
            step;
            n_vec += 2;
            if (edge_cnt !== ee) begin n_err++; $display("FAIL wrap_edge n=%0d got %0d exp %0d", i, edge_cnt, ee); end
            if (bit_cnt !== eb)  begin n_err++; $display("FAIL wrap_bit n=%0d got %0d exp %0d", i, bit_cnt, eb); end
        end
        enable = 1'b0;
    endtask

    task automatic test_clear_priority;
        prescale = P_W'(8);
        clear_counters;
        enable = 1'b1;
        repeat (39) step;
        n_vec += 2;
        if (edge_cnt !== P_W'(7)) begin n_err++; $display("FAIL prio_pre_edge got %0d exp 7", edge_cnt); end
        if (bit_cnt !== B_W'(4))  begin n_err++; $display("FAIL prio_pre_bit got %0d exp 4", bit_cnt); end
        reset_counters = 1'b1;
        step;
        reset_counters = 1'b0;
        n_vec += 2;
        if (edge_cnt !== '0) begin n_err++; $display("FAIL prio_clr_edge got %0d exp 0", edge_cnt); end
        if (bit_cnt !== '0)  begin n_err++; $display("FAIL prio_clr_bit got %0d exp 0", bit_cnt); end
        repeat (3) step;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            n_vec += 2;
            if (edge_cnt !== P_W'(3)) begin n_err++; $display("FAIL hold_edge cyc=%0d got %0d exp 3", i, edge_cnt); end
            if (bit_cnt !== '0)       begin n_err++; $display("FAIL hold_bit cyc=%0d got %0d exp 0", i, bit_cnt); end
        end
    endtask

    task automatic test_wrap_guard;
        prescale = P_W'(16);
        clear_counters;
        enable = 1'b1;
        repeat (12) step;
        prescale = P_W'(8);
        step;
        n_vec += 2;
        if (edge_cnt !== '0)      begin n_err++; $display("FAIL guard_edge got %0d exp 0", edge_cnt); end
        if (bit_cnt !== B_W'(1))  begin n_err++; $display("FAIL guard_bit got %0d exp 1", bit_cnt); end
        step;
        n_vec++;
        if (edge_cnt !== P_W'(1)) begin n_err++; $display("FAIL guard_next_edge got %0d exp 1", edge_cnt); end
        enable = 1'b0;
    endtask

    task automatic test_random_count;
        for (int pass = 0; pass < 2; pass++) begin
            int p = (pass == 0) ? 8 : 32;
            int n = 0;
            prescale = P_W'(p);
            clear_counters;
            for (int i = 0; i < 500; i++) begin
                logic en  = ($urandom_range(0, 9) < 7);
                logic clr = ($urandom_range(0, 59) == 0);
                logic [P_W-1:0] ee;
                logic [B_W-1:0] eb;
                enable = en;
                reset_counters = clr;
                step;
                if (clr) n = 0;
                else if (en) n++;
                ee = P_W'(n % p);
                eb = B_W'(((n / p) > 15) ? 15 : (n / p));
                n_vec += 2;
                if (edge_cnt !== ee) begin n_err++; $display("FAIL rnd_edge p=%0d n=%0d got %0d exp %0d", p, n, edge_cnt, ee); end
                if (bit_cnt !== eb)  begin n_err++; $display("FAIL rnd_bit p=%0d n=%0d got %0d exp %0d", p, n, bit_cnt, eb); end
            end
            reset_counters = 1'b0;
            enable = 1'b0;
        end
    endtask

    // Replays line[] so that rx_sync equals line[w] in window w after the clear.
    task automatic run_bits(input int p, input int nbits, input logic dse_v,
                            input logic perr_v, output int nvalid);
        int total = nbits * p;
        int mid = p / 2;
        nvalid = 0;
        prescale = P_W'(p);
        enable = 1'b0;
        data_sample_enable = 1'b0;
        reset_counters = 1'b0;
        RX_IN = line[0];
        step;
        RX_IN = line[1];
        reset_counters = 1'b1;
        step;
        reset_counters = 1'b0;
        enable = 1'b1;
        data_sample_enable = dse_v;
        for (int w = 0; w < total; w++) begin
            int b = w / p;
            int k = w % p;
            logic ev = dse_v && !perr_v && (k == mid + 3);
            logic [P_W-1:0] ee = P_W'(k);
            logic [B_W-1:0] eb = B_W'((b > 15) ? 15 : b);
            if (ev) exp_sb = maj(line[b*p+mid-1], line[b*p+mid], line[b*p+mid+1]);
            n_vec += 5;
            if (edge_cnt !== ee)         begin n_err++; $display("FAIL seq_edge p=%0d w=%0d got %0d exp %0d", p, w, edge_cnt, ee); end
            if (bit_cnt !== eb)          begin n_err++; $display("FAIL seq_bit p=%0d w=%0d got %0d exp %0d", p, w, bit_cnt, eb); end
            if (prescale_err !== perr_v) begin n_err++; $display("FAIL seq_perr p=%0d w=%0d got %b exp %b", p, w, prescale_err, perr_v); end
            if (sample_valid !== ev)     begin n_err++; $display("FAIL seq_valid p=%0d w=%0d got %b exp %b", p, w, sample_valid, ev); end
            if (sampled_bit !== exp_sb)  begin n_err++; $display("FAIL seq_sampled p=%0d w=%0d got %b exp %b", p, w, sampled_bit, exp_sb); end
            if (sample_valid === 1'b1) nvalid++;
            RX_IN = line[w+2];
            step;
        end
        enable = 1'b0;
        data_sample_enable = 1'b0;
        RX_IN = 1'b1;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < 512; i++) line[i] = (i < len) ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic test_majority;
        int nv;
        fill_random(6 * 16);
        line[7]  = 1'b1; line[8]  = 1'b0; line[9]  = 1'b1;
        line[23] = 1'b0; line[24] = 1'b0; line[25] = 1'b1;
        run_bits(16, 6, 1'b1, 1'b0, nv);
        n_vec++;
        if (nv != 6) begin n_err++; $display("FAIL majority_pulses got %0d exp 6", nv); end
    endtask

    task automatic test_frame;
        int nv;
        logic [7:0] data = 8'h5A;
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < 512; i++) line[i] = 1'b1;
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 8; k++) line[b*8+k] = frame[b];
        run_bits(8, 10, 1'b1, 1'b0, nv);
        n_vec++;
        if (nv != 10) begin n_err++; $display("FAIL frame_pulses got %0d exp 10", nv); end
    endtask

    task automatic test_random_frames;
        for (int r = 0; r < 4; r++) begin
            int nv;
            int sel = $urandom_range(0, 2);
            int p = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
            int nb = $urandom_range(3, 7);
            fill_random(nb * p);
            run_bits(p, nb, 1'b1, 1'b0, nv);
            n_vec++;
            if (nv != nb) begin n_err++; $display("FAIL rnd_frame_pulses p=%0d got %0d exp %0d", p, nv, nb); end
        end
    endtask

    task automatic test_no_sample_enable;
        int nv;
        fill_random(4 * 16);
        run_bits(16, 4, 1'b0, 1'b0, nv);
        n_vec++;
        if (nv != 0) begin n_err++; $display("FAIL nodse_pulses got %0d exp 0", nv); end
    endtask

    task automatic test_illegal_prescale;
        int nv;
        prescale = P_W'(16);
        step;
        n_vec++;
        if (prescale_err !== 1'b0) begin n_err++; $display("FAIL perr_legal got %b exp 0", prescale_err); end
        prescale = P_W'(12);
        step;
        n_vec++;
        if (prescale_err !== 1'b1) begin n_err++; $display("FAIL perr_next got %b exp 1", prescale_err); end
        fill_random(3 * 12);
        run_bits(12, 3, 1'b1, 1'b1, nv);
        n_vec++;
        if (nv != 0) begin n_err++; $display("FAIL perr_pulses got %0d exp 0", nv); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_sb = 1'b1;
        test_reset;
        test_wrap;
        test_clear_priority;
        test_wrap_guard;
        test_random_count;
        test_majority;
        test_frame;
        test_random_frames;
        test_no_sample_enable;
        test_illegal_prescale;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
